// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with valid/ready handshakes and iterative MULU/DIVU/REMU
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             DivZero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic               ready_en;
    logic               accept, is_iter, last_iter;
    logic [3:0]         op;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_step;
    logic [WIDTH-1:0]   mplier, divisor, quo, quo_step;
    logic [WIDTH:0]     rem, rem_step, shifted, trial;
    logic               ge;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_res, it_res;
    logic               sc_c, sc_o, it_c, it_dz;

    // in_ready must stay low while in reset and rise on the first edge after release,
    // so it is gated by a flop rather than decoded from IDLE alone.
    assign in_ready  = ready_en && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_iter   = (ALU_Sel == OP_MULU) || (ALU_Sel == OP_DIVU) || (ALU_Sel == OP_REMU);
    assign last_iter = (cnt == SHW'(WIDTH - 1));

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        sum    = {1'b0, A} + {1'b0, B};
        diff   = A - B;
        case (ALU_Sel)
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_c   = (A >= B);
                sc_o   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOT:  sc_res = ~A;
            OP_SLL:  sc_res = A << B[SHW-1:0];
            OP_SRL:  sc_res = A >> B[SHW-1:0];
            OP_SRA:  sc_res = $signed(A) >>> B[SHW-1:0];
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: sc_res = '0;
        endcase
    end

    // One shift-add step and one restoring-division step per BUSY cycle.
    // With a zero divisor every trial subtract succeeds, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        acc_step = mplier[0] ? (acc + mcand) : acc;
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        ge       = (shifted >= {1'b0, divisor});
        rem_step = ge ? trial : shifted;
        quo_step = {quo[WIDTH-2:0], ge};
        it_res   = '0;
        it_c     = 1'b0;
        it_dz    = 1'b0;
        case (op)
            OP_MULU: begin
                it_res = acc_step[WIDTH-1:0];
                it_c   = |acc_step[2*WIDTH-1:WIDTH];
            end
            OP_DIVU: begin
                it_res = quo_step;
                it_dz  = (divisor == '0);
            end
            OP_REMU: begin
                it_res = rem_step[WIDTH-1:0];
                it_dz  = (divisor == '0);
            end
            default: it_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_iter ? BUSY : DONE;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else if (accept) begin
            op      <= ALU_Sel;
            cnt     <= '0;
            mcand   <= {{WIDTH{1'b0}}, A};
            acc     <= '0;
            mplier  <= B;
            divisor <= B;
            quo     <= A;
            rem     <= '0;
            if (!is_iter) begin
                Result   <= sc_res;
                Zero     <= (sc_res == '0);
                Carry    <= sc_c;
                Overflow <= sc_o;
                DivZero  <= 1'b0;
            end
        end else if (state == BUSY) begin
            cnt    <= cnt + 1'b1;
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_step;
            quo    <= quo_step;
            if (last_iter) begin
                Result   <= it_res;
                Zero     <= (it_res == '0);
                Carry    <= it_c;
                Overflow <= 1'b0;
                DivZero  <= it_dz;
            end
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle successor to the team's combinational 32-bit ALU.
- Keeps the existing 10 single-cycle operations and their encodings, adds iterative unsigned multiply, divide and remainder, and wraps everything in valid/ready handshakes on both sides.
- Sits between the decode/issue stage and writeback.
- Processes one operation at a time; a new operation is accepted only after the previous result has been consumed.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_Sel  input  4  operation select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  registered result.
- Zero  output  1  Result == 0.
- Carry  output  1  carry / no-borrow / multiply-overflow.
- Overflow  output  1  signed overflow.
- DivZero  output  1  divisor was zero (DIVU/REMU only).

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is asynchronous and active-low: rst_n.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, Result=0, Zero=0, Carry=0, Overflow=0, DivZero=0, iteration counter=0.
  - in_ready rises on the first clk edge after deassertion.
  - Reset mid-operation aborts it; the in-flight result is lost.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- Transitions:
  - Accept on in_valid & in_ready at a clk edge. A, B and ALU_Sel are captured then; later input changes are ignored.
  - Single-cycle ops (0000–1001): IDLE→DONE at the accept edge. out_valid is visible one cycle after accept.
  - Iterative ops (1010–1100): IDLE→BUSY. Exactly WIDTH BUSY cycles, counter 0..WIDTH-1, then BUSY→DONE. out_valid is visible WIDTH+1 cycles after accept.
  - DONE→IDLE on out_valid & out_ready. Result and flags hold stable while out_valid=1 and out_ready=0.
  - No accept while in BUSY or DONE (in_ready=0). Back-to-back throughput is 1 op per 2 cycles minimum.
- Operations (Carry/Overflow 0 unless stated):
  - 0000 ADD: {Carry,Result}=A+B. Overflow = same-sign operands, different-sign result.
  - 0001 SUB: Result=A−B. Carry=1 if A≥B unsigned (no borrow). Overflow = differing operand signs and result sign ≠ A sign.
  - 0010 AND. 0011 OR. 0100 XOR. 0101 NOT A.
  - 0110 SLL / 0111 SRL / 1000 SRA: shift A by B[SHW-1:0]. SRA sign-fills.
  - 1001 SLT: Result=1 if $signed(A)<$signed(B), else 0.
  - 1010 MULU: Result = low WIDTH bits of the unsigned product, by shift-add, one bit per cycle. Carry=1 if the high WIDTH bits are non-zero.
  - 1011 DIVU: unsigned quotient, restoring division, one bit per cycle.
  - 1100 REMU: unsigned remainder, same datapath as DIVU.
  - 1101–1111: treated as single-cycle, Result=0, all flags 0.
- Divide by zero (B=0):
  - Still takes WIDTH cycles.
  - DIVU Result = all ones; REMU Result = A; DivZero=1.
  - DivZero=0 for every other op and for non-zero divisors.
- Zero flag: computed from the final registered Result for every op, including defaults.
- Internal widths:
  - Multiply: 2·WIDTH accumulator.
  - Divide: WIDTH+1 partial remainder.
  - No truncation before the final result.

Test Plan:
- Reset / ADD / handshake hold (WIDTH=32): assert rst_n=0 mid-BUSY of a MULU → all outputs 0 immediately; release. Then ADD A=0xFFFFFFFF, B=1 → one cycle later out_valid=1, Result=0, Zero=1, Carry=1, Overflow=0. Hold out_ready=0 for 5 cycles → values stable, in_ready=0.
- SUB / SLT: SUB A=0x80000000, B=1 → Result=0x7FFFFFFF, Overflow=1, Carry=1. SLT A=0xFFFFFFFF, B=0 → Result=1.
- Shifts: SRA A=0x80000000, B=0x24 (shift 4) → Result=0xF8000000. SLL A=1, B=31 → Result=0x80000000.
- MULU: A=0x00010000, B=0x00010000 → out_valid exactly 33 cycles after accept, Result=0, Zero=1, Carry=1. A=7, B=6 → Result=42, Carry=0.
- DIVU / REMU: DIVU A=100, B=7 → Result=14. REMU → Result=2, DivZero=0. DIVU A=5, B=0 → Result=0xFFFFFFFF, DivZero=1. REMU A=5, B=0 → Result=5.
- Width and throughput: WIDTH=8 instance, MULU A=0x10, B=0x10 → Result=0x00, Carry=1, latency 9 cycles. in_valid held high with out_ready=1 → accepts exactly every 2nd cycle for single-cycle ops.
